// File: rtl/shuttle_if.sv
// Shuttle dispatcher bus: strobes and requests into the dispatcher, position/status/pulse outputs back.
interface shuttle_if;
    logic       tick;
    logic       req_b1;
    logic       req_b2;
    logic       refuel_req;
    logic [6:0] pos;
    logic       dir;
    logic [1:0] state;
    logic [1:0] wait_b1;
    logic [1:0] wait_b2;
    logic [1:0] load;
    logic       fare_valid;
    logic [6:0] fare;
    logic       refuel_ack;
    logic       drop;

    modport master (
        output tick, req_b1, req_b2, refuel_req,
        input  pos, dir, state, wait_b1, wait_b2, load, fare_valid, fare, refuel_ack, drop
    );

    modport slave (
        input  tick, req_b1, req_b2, refuel_req,
        output pos, dir, state, wait_b1, wait_b2, load, fare_valid, fare, refuel_ack, drop
    );
endinterface

// File: rtl/shuttle_dispatcher.sv
// Two-stop shuttle controller: queues riders at B1/B2, boards, runs a 7-slot track with a refuel hold at the middle.
// Optional idle-return to B1 when sitting empty at B2 is enabled by defining AUTO_RETURN_EN.
//
// state  | meaning
// IDLE   | parked at B1 or B2, waiting for a rider at either stop
// BOARD  | riders taken on, first move pending
// RUN    | moving one slot per tick, may hold at the station
// ALIGHT | at the far stop, unload and turn around
module shuttle_dispatcher #(
    parameter int RETURN_TICKS = 8
) (
    input logic      clk,
    input logic      rst,
    shuttle_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOARD  = 2'd1,
        S_RUN    = 2'd2,
        S_ALIGHT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       at_b1;
    logic [1:0] wait_here, wait_other;
    logic [6:0] pos_step;
    logic [6:0] fare_calc;
    logic       auto_go, board_go, move, refuel_hold, alight;
    logic       clr_b1, clr_b2;

    if (RETURN_TICKS < 1) begin : g_bad_param
        $error("RETURN_TICKS must be at least 1");
    end

    assign at_b1      = bus.pos[0];
    assign wait_here  = at_b1 ? bus.wait_b1 : bus.wait_b2;
    assign wait_other = at_b1 ? bus.wait_b2 : bus.wait_b1;
    assign bus.state  = state_q;

    // Ends saturate so pos can never walk off the track.
    always_comb begin
        pos_step = bus.pos;
        if (bus.dir) begin
            if (!bus.pos[0]) pos_step = bus.pos >> 1;
        end else begin
            if (!bus.pos[6]) pos_step = bus.pos << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.tick) begin
            case (state_q)
                S_IDLE:   if (wait_here != 2'd0 || wait_other != 2'd0 || auto_go) state_d = S_BOARD;
                S_BOARD:  state_d = S_RUN;
                S_RUN:    if (!refuel_hold && (pos_step[0] || pos_step[6])) state_d = S_ALIGHT;
                S_ALIGHT: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        refuel_hold = (state_q == S_RUN) && bus.pos[3] && bus.refuel_req;
        board_go    = bus.tick && (state_q == S_IDLE) && (state_d == S_BOARD);
        move        = bus.tick && ((state_q == S_BOARD) || ((state_q == S_RUN) && !refuel_hold));
        alight      = bus.tick && (state_q == S_ALIGHT);
        clr_b1      = board_go && at_b1;
        clr_b2      = board_go && !at_b1;
    end

    always_comb begin
        case (wait_here)
            2'd1:    fare_calc = at_b1 ? 7'd30 : 7'd20;
            2'd2:    fare_calc = at_b1 ? 7'd60 : 7'd40;
            default: fare_calc = 7'd0;
        endcase
    end

`ifdef AUTO_RETURN_EN
    localparam int RW = $clog2(RETURN_TICKS + 1);
    logic [RW-1:0] rt_cnt;
    logic          rt_arm, any_req;

    assign rt_arm  = (state_q == S_IDLE) && bus.pos[6] && (bus.load == 2'd0)
                     && (bus.wait_b1 == 2'd0) && (bus.wait_b2 == 2'd0);
    assign any_req = bus.req_b1 || bus.req_b2;
    assign auto_go = rt_arm && bus.tick && !any_req && (rt_cnt == RW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    rt_cnt <= RW'(RETURN_TICKS);
        else if (!rt_arm || any_req) rt_cnt <= RW'(RETURN_TICKS);
        else if (bus.tick)          rt_cnt <= (rt_cnt == RW'(1)) ? RW'(RETURN_TICKS) : rt_cnt - RW'(1);
    end
`else
    assign auto_go = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pos        <= 7'b0000001;
            bus.dir        <= 1'b0;
            bus.load       <= 2'd0;
            bus.wait_b1    <= 2'd0;
            bus.wait_b2    <= 2'd0;
            bus.fare       <= 7'd0;
            bus.fare_valid <= 1'b0;
            bus.refuel_ack <= 1'b0;
            bus.drop       <= 1'b0;
        end else begin
            bus.fare_valid <= board_go && (wait_here != 2'd0);
            bus.refuel_ack <= bus.tick && refuel_hold;
            bus.drop       <= (bus.req_b1 && bus.wait_b1 == 2'd2 && !clr_b1)
                           || (bus.req_b2 && bus.wait_b2 == 2'd2 && !clr_b2);

            if (move) bus.pos <= pos_step;

            if (board_go) begin
                bus.load <= wait_here;
                if (wait_here != 2'd0) bus.fare <= fare_calc;
            end

            if (alight) begin
                bus.load <= 2'd0;
                bus.dir  <= ~bus.dir;
            end

            // A request landing on the boarding cycle stays queued for the next trip.
            if (clr_b1)                                bus.wait_b1 <= {1'b0, bus.req_b1};
            else if (bus.req_b1 && bus.wait_b1 != 2'd2) bus.wait_b1 <= bus.wait_b1 + 2'd1;

            if (clr_b2)                                bus.wait_b2 <= {1'b0, bus.req_b2};
            else if (bus.req_b2 && bus.wait_b2 != 2'd2) bus.wait_b2 <= bus.wait_b2 + 2'd1;
        end
    end
endmodule

// File: tb/tb_shuttle_dispatcher.sv
// Directed bench for shuttle_dispatcher: trips both ways, queue saturation, refuel hold, mid-run reset, idle return.
module tb_shuttle_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;
    int   fv_cnt = 0, drop_cnt = 0, ack_cnt = 0;

    shuttle_if bus ();

    shuttle_dispatcher #(.RETURN_TICKS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fare_valid === 1'b1) fv_cnt++;
        if (bus.drop === 1'b1)       drop_cnt++;
        if (bus.refuel_ack === 1'b1) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk with the given strobes high; returns 1 time unit after the edge.
    task automatic cycle(input logic t, input logic r1, input logic r2);
        @(negedge clk);
        bus.tick = t; bus.req_b1 = r1; bus.req_b2 = r2;
        @(posedge clk);
        #1;
        bus.tick = 1'b0; bus.req_b1 = 1'b0; bus.req_b2 = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        settle();
        fv_cnt = 0; drop_cnt = 0; ack_cnt = 0;
    endtask

    initial begin
        bus.tick = 1'b0; bus.req_b1 = 1'b0; bus.req_b2 = 1'b0; bus.refuel_req = 1'b0;

        // Reset state; requests during reset are discarded
        repeat (2) @(posedge clk);
        cycle(1'b1, 1'b1, 1'b1);
        check("rst_pos", bus.pos, 1);
        check("rst_state", bus.state, 0);
        check("rst_dir", bus.dir, 0);
        check("rst_wait_b1", bus.wait_b1, 0);
        check("rst_wait_b2", bus.wait_b2, 0);
        check("rst_load", bus.load, 0);
        check("rst_fare", bus.fare, 0);
        check("rst_fare_valid", bus.fare_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_counts();

        // Two riders at B1, full trip to B2
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("t1_wait_b1", bus.wait_b1, 2);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("t1_hold_no_tick", bus.state, 0);
        cycle(1'b1, 1'b0, 1'b0);
        check("t1_board_state", bus.state, 1);
        check("t1_fare_valid", bus.fare_valid, 1);
        check("t1_fare", bus.fare, 60);
        check("t1_load", bus.load, 2);
        check("t1_wait_clr", bus.wait_b1, 0);
        for (int t = 2; t <= 7; t++) begin
            int exp_pos;
            exp_pos = 1 << (t - 1);
            cycle(1'b1, 1'b0, 1'b0);
            check($sformatf("t1_pos_tick%0d", t), bus.pos, exp_pos);
            if (t == 4) check("t1_load_run", bus.load, 2);
        end
        check("t1_alight", bus.state, 3);
        cycle(1'b1, 1'b0, 1'b0);
        check("t1_idle", bus.state, 0);
        check("t1_dir", bus.dir, 1);
        check("t1_load_end", bus.load, 0);
        check("t1_pos_end", bus.pos, 64);
        settle();
        check("t1_fv_once", fv_cnt, 1);
        check("t1_fare_kept", bus.fare, 60);

        // Queue saturation at B2, then board two and refuel-hold on the way back
        clear_counts();
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        settle();
        check("sat_wait_b2", bus.wait_b2, 2);
        check("sat_drop_once", drop_cnt, 1);
        cycle(1'b1, 1'b0, 1'b0);
        check("b2_fare", bus.fare, 40);
        check("b2_load", bus.load, 2);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        check("rf_at_station", bus.pos, 8);
        ack_cnt = 0;
        bus.refuel_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check($sformatf("rf_hold%0d", k), bus.pos, 8);
        end
        bus.refuel_req = 1'b0;
        settle();
        check("rf_ack_cnt", ack_cnt, 3);
        cycle(1'b1, 1'b0, 1'b0);
        check("rf_resume", bus.pos, 4);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        check("rf_arrive_b1", bus.pos, 1);
        check("rf_alight", bus.state, 3);
        cycle(1'b1, 1'b0, 1'b0);
        check("rf_idle_dir", bus.dir, 0);

        // Empty departure from B1 for a B2 rider
        clear_counts();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        check("ed_board", bus.state, 1);
        check("ed_load", bus.load, 0);
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        check("ed_pos_b2", bus.pos, 64);
        check("ed_alight", bus.state, 3);
        cycle(1'b1, 1'b0, 1'b0);
        settle();
        check("ed_no_fare", fv_cnt, 0);
        check("ed_wait_kept", bus.wait_b2, 1);
        // Boarding coincides with a fresh B2 request
        cycle(1'b1, 1'b0, 1'b1);
        check("ed_fare_valid", bus.fare_valid, 1);
        check("ed_fare", bus.fare, 20);
        check("coin_load", bus.load, 1);
        check("coin_wait_b2", bus.wait_b2, 1);
        repeat (7) cycle(1'b1, 1'b0, 1'b0);
        check("coin_back_b1", bus.state, 0);

        // Reset mid-run at bit4 with one rider aboard
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("mr_fare", bus.fare, 30);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        check("mr_pos_bit4", bus.pos, 16);
        check("mr_load1", bus.load, 1);
        clear_counts();
        #2;
        rst = 1'b1;
        #1;
        check("mr_pos", bus.pos, 1);
        check("mr_load", bus.load, 0);
        check("mr_state", bus.state, 0);
        check("mr_wait_b2", bus.wait_b2, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("mr_no_pulses", fv_cnt + drop_cnt + ack_cnt, 0);

        // Park empty at B2, then watch the idle behaviour
        cycle(1'b0, 1'b1, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        check("ar_parked", bus.pos, 64);
        clear_counts();
        repeat (7) cycle(1'b1, 1'b0, 1'b0);
        check("ar_idle7", bus.state, 0);
        cycle(1'b1, 1'b0, 1'b0);
`ifdef AUTO_RETURN_EN
        check("ar_depart8", bus.state, 1);
        check("ar_load0", bus.load, 0);
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        check("ar_pos_b1", bus.pos, 1);
`else
        check("ar_stay8", bus.state, 0);
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        check("ar_pos_b2", bus.pos, 64);
`endif
        settle();
        check("ar_no_fare", fv_cnt, 0);
        check("ar_fare_kept", bus.fare, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/shuttle_dispatcher.md
SHUTTLE_DISPATCHER -- requirements
Module: shuttle_dispatcher

Interface
REQ-001 SHALL have parameter RETURN_TICKS, default 8: number of idle ticks at B2 before an empty return to B1 (used only under REQ-029).
REQ-002 SHALL have input clk, 1 bit: system clock; all state changes occur on its rising edge.
REQ-003 SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have input tick, 1 bit: movement strobe, one clk wide; FSM/position advance only on cycles with tick=1.
REQ-005 SHALL have inputs req_b1, req_b2, 1 bit each: one-cycle passenger-arrival pulses at stop B1 (pos bit0) and B2 (pos bit6).
REQ-006 SHALL have input refuel_req, 1 bit: gas station requests a hold at the middle position (pos bit3).
REQ-007 SHALL have output pos, 7 bits: one-hot bus position, bit0=B1, bit3=station, bit6=B2.
REQ-008 SHALL have outputs dir (1 bit, 0=toward B2, 1=toward B1) and state (2 bits: 0 IDLE, 1 BOARD, 2 RUN, 3 ALIGHT).
REQ-009 SHALL have outputs wait_b1, wait_b2 (2 bits each, count 0-2) and load (2 bits, passengers on bus, 0-2).
REQ-010 SHALL have outputs fare_valid (1 bit pulse) and fare (7 bits, 0-60), plus refuel_ack and drop (1-bit pulses).

Function
REQ-011 SHALL sample req_b1/req_b2 every clk cycle, independent of tick: wait_bX increments by 1, saturating at 2.
REQ-012 SHALL pulse drop for one cycle when a request arrives while that stop's wait count is 2; count unchanged.
REQ-013 SHALL, in IDLE on tick, with "here" = stop given by pos: wait_here>0 -> BOARD; else wait_other>0 -> BOARD with zero boarders (empty departure); else remain IDLE.
REQ-014 SHALL, on the IDLE->BOARD tick, set load<=wait_here, clear wait_here, pulse fare_valid for one cycle with fare=30*load at B1, 20*load at B2 (fare_valid=0 if load=0).
REQ-015 SHALL, when a request for the boarding stop coincides with the boarding cycle, board the prior count and leave wait_here=1 afterward.
REQ-016 SHALL, in BOARD on tick, shift pos one step in dir and enter RUN.
REQ-017 SHALL, in RUN on tick, shift pos one step in dir; when the new pos is bit0 or bit6, enter ALIGHT.
REQ-018 SHALL, in RUN on tick with pos=bit3 and refuel_req=1, hold pos and pulse refuel_ack; repeat each tick while refuel_req=1, resume motion on the first tick with refuel_req=0.
REQ-019 SHALL, in ALIGHT on tick, set load<=0, invert dir, enter IDLE; applies also when load=0.
REQ-020 SHALL never shift pos outside bits 0..6; pos is always exactly one-hot.
REQ-021 SHALL keep fare at its last value when fare_valid=0; fare arithmetic max 60, no overflow in 7 bits.
REQ-022 SHALL hold all state with tick=0, except request queueing (REQ-011/012).
REQ-023 Latency: request at B1 with bus idle at B1 -> fare_valid on 1st tick, pos=bit6 and ALIGHT on 7th tick, IDLE at B2 with load=0 on 8th tick (no refuel hold).

Reset
REQ-024 SHALL, on rst=1, asynchronously set pos=7'b0000001, dir=0, state=IDLE, wait_b1=wait_b2=load=0, fare=0.
REQ-025 SHALL hold fare_valid, refuel_ack, drop at 0 during reset; requests during reset are discarded.
REQ-026 SHALL, on reset mid-run, abandon onboard and waiting passengers; no fare, drop or ack pulse on release.
REQ-027 SHALL clear the idle-return counter on reset.

Configuration
REQ-028 Macro AUTO_RETURN_EN SHALL select the idle-return feature.
REQ-029 With AUTO_RETURN_EN: in IDLE at B2 with load=0 and both waits 0, count ticks; on RETURN_TICKS-th such tick enter BOARD with zero boarders toward B1; counter clears on any request or on leaving IDLE.
REQ-030 Without AUTO_RETURN_EN: counter absent; bus idles at B2 indefinitely until a request arrives.

Verification
REQ-031 Reset; req_b1 x2; 8 ticks -> fare_valid once with fare=60, load=2 during run, pos=bit6, IDLE, dir=1, load=0.
REQ-032 req_b1 x3 in idle -> wait_b1=2, drop pulses exactly once.
REQ-033 Bus idle at B1, req_b2 only -> empty departure, fare_valid never asserted, arrives B2 on 7th tick; next tick with wait_b2=1 -> fare=20.
REQ-034 refuel_req=1 for 3 ticks while pos=bit3 in RUN -> 3 refuel_ack pulses, pos fixed at bit3, then motion resumes.
REQ-035 rst asserted at pos=bit4 with load=1 -> immediate pos=bit0, load=0, state IDLE, no pulses.
REQ-036 With AUTO_RETURN_EN, RETURN_TICKS=8, bus idle empty at B2 -> departs on 8th idle tick, pos=bit0 after 6 more ticks; without macro, stays at bit6.
